// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared constants and types for alu16 and alu16_seq
// Purpose: data width, 3-bit opcode constants and the sequencer FSM state type.
// Ports: none (package).
package alu16_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu16.sv
// rtl/alu16.sv - combinational 16-bit ALU with zero/carry/sign flags
// Purpose: computes y = f(op, a, b) and the flags for that result.
// Ports:
//   op  in  3   opcode (ADD SUB AND OR XOR MOV SHL SHR)
//   a   in  16  operand A
//   b   in  16  operand B (MOV passes b; shifts use b[3:0] as amount)
//   y   out 16  result
//   zf  out 1   y == 0
//   cf  out 1   ADD carry-out, SUB borrow, last bit shifted out (0 for a zero shift)
//   sf  out 1   y[15]
module alu16
  import alu16_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zf,
  output logic              cf,
  output logic              sf
);

  logic [3:0]        shamt;
  logic [DATA_W:0]   shl_w;
  logic [DATA_W:0]   shr_w;

  assign shamt = b[3:0];
  // One guard bit on the side the data leaves: it ends up holding the
  // last bit shifted out, and stays 0 when the amount is 0.
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  always_comb begin
    y  = '0;
    cf = 1'b0;
    case (op)
      OP_ADD:  {cf, y} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {cf, y} = {1'b0, a} - {1'b0, b};
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MOV:  y = b;
      OP_SHL:  {cf, y} = shl_w;
      OP_SHR:  {y, cf} = shr_w;
      default: y = '0;
    endcase
    zf = (y == '0);
    sf = y[DATA_W-1];
  end

endmodule

// File: rtl/alu16_seq.sv
// rtl/alu16_seq.sv - register file and handshake sequencer around alu16
// Purpose: accepts one instruction per in_valid/in_ready handshake, reads
// operands from the register file, runs alu16, writes back and presents the
// latched result and flags until out_ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          instruction handshake (in_ready high only in IDLE)
//   in_op, in_rd, in_ra, in_rb instruction fields
//   in_use_imm, in_imm         operand B select / immediate
//   out_valid/out_ready        result handshake
//   out_result, out_zf/cf/sf   latched result and flags
//   dbg_sel/dbg_data           combinational register peek
//   instr_cnt                  retired-instruction count (wraps)
module alu16_seq
  import alu16_pkg::*;
#(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zf,
  output logic              out_cf,
  output logic              out_sf,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int NREGS = 1 << REG_AW;

  state_t              state;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [REG_AW-1:0]   ra_q;
  logic [REG_AW-1:0]   rb_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  logic [DATA_W-1:0]   alu_y;
  logic                alu_zf;
  logic                alu_cf;
  logic                alu_sf;

  alu16 u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y),
    .zf (alu_zf),
    .cf (alu_cf),
    .sf (alu_sf)
  );

  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zf     <= 1'b0;
      out_cf     <= 1'b0;
      out_sf     <= 1'b0;
      instr_cnt  <= '0;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q      <= in_op;
            rd_q      <= in_rd;
            ra_q      <= in_ra;
            rb_q      <= in_rb;
            use_imm_q <= in_use_imm;
            imm_q     <= in_imm;
            in_ready  <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          // Previous writeback landed at its EXEC edge, so no bypass is needed.
          a_q   <= regs[ra_q];
          b_q   <= use_imm_q ? imm_q : regs[rb_q];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          out_result  <= alu_y;
          out_zf      <= alu_zf;
          out_cf      <= alu_cf;
          out_sf      <= alu_sf;
          regs[rd_q]  <= alu_y;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            instr_cnt <= instr_cnt + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// tb/tb_alu16_seq.sv - self-checking bench for alu16_seq
module tb_alu16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_ra;
  logic [1:0]  in_rb;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zf;
  logic        out_cf;
  logic        out_sf;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [15:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  int model_r [4];
  int model_cnt = 0;

  alu16_seq #(.REG_AW(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zf     (out_zf),
    .out_cf     (out_cf),
    .out_sf     (out_sf),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic; returns {cf, y}.
  function automatic logic [16:0] ref_alu(input int op, input int a, input int b);
    int r;
    int c;
    int n;
    n = b % 16;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 65535) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = b;
      6: begin r = a * (1 << n); c = (r / 65536) % 2; end
      default: begin r = a / (1 << n); c = (n == 0) ? 0 : (a / (1 << (n - 1))) % 2; end
    endcase
    r = r & 16'hFFFF;
    return {c[0], r[15:0]};
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, model_r[i]);
    end
  endtask

  task automatic issue(input int op, input int rd, input int ra, input int rb,
                       input int ui, input int imm, input int stall);
    int a;
    int b;
    int lat;
    logic [16:0] res;
    logic [15:0] held;
    check("in_ready_idle", in_ready, 1);
    in_valid   = 1'b1;
    in_op      = 3'(op);
    in_rd      = 2'(rd);
    in_ra      = 2'(ra);
    in_rb      = 2'(rb);
    in_use_imm = ui[0];
    in_imm     = 16'(imm);
    out_ready  = (stall == 0);
    a = model_r[ra];
    b = (ui != 0) ? imm : model_r[rb];
    res = ref_alu(op, a, b);
    @(posedge clk); #1;
    // Scramble the source after the handshake; busy states must ignore it.
    in_valid   = 1'($urandom_range(0, 1));
    in_op      = 3'($urandom);
    in_rd      = 2'($urandom);
    in_ra      = 2'($urandom);
    in_rb      = 2'($urandom);
    in_use_imm = 1'($urandom);
    in_imm     = 16'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 2);
    in_valid = 1'b0;
    model_r[rd] = res[15:0];
    check("result", out_result, res[15:0]);
    check("zf", out_zf, (res[15:0] == 16'h0));
    check("cf", out_cf, res[16]);
    check("sf", out_sf, res[15]);
    check_regs("rf");
    held = res[15:0];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", out_result, held);
      check("stall_cnt", instr_cnt, model_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % 65536;
    check("retire_cnt", instr_cnt, model_cnt);
    check("retire_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
    in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b0; dbg_sel = '0;
    for (int i = 0; i < 4; i++) model_r[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {out_zf, out_cf, out_sf}, 0);
    check("rst_cnt", instr_cnt, 0);
    check_regs("rst");

    // Directed cases
    issue(5, 0, 0, 0, 1, 16'h1234, 0);
    issue(5, 1, 0, 0, 1, 16'h00FF, 0);
    check("cnt_after_loads", instr_cnt, 2);
    issue(5, 2, 0, 0, 1, 16'hFFFF, 0);
    issue(0, 3, 2, 0, 1, 16'h0001, 0);
    issue(1, 0, 1, 0, 0, 0, 0);
    check("sub_value", out_result, 16'hEECB);
    issue(4, 2, 0, 0, 1, 16'hFFFF, 0);
    check("xor_dep", out_result, 16'h1134);
    issue(5, 0, 0, 0, 1, 16'h8001, 0);
    issue(6, 1, 0, 0, 1, 1, 0);
    issue(7, 1, 0, 0, 1, 0, 0);
    issue(0, 3, 3, 3, 0, 0, 10);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 65535),
            $urandom_range(0, 2));
    end

    // Async reset while the ADD is in EXEC
    issue(5, 0, 0, 0, 1, 16'h0055, 0);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 2'd1; in_ra = 2'd0;
    in_use_imm = 1'b1; in_imm = 16'h0005; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_r[i] = 0;
    model_cnt = 0;
    check("abort_valid", out_valid, 0);
    check("abort_cnt", instr_cnt, 0);
    check("abort_result", out_result, 0);
    check_regs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1);
    issue(5, 1, 0, 0, 1, 16'h0007, 0);
    issue(0, 2, 1, 1, 0, 0, 1);
    check("post_rst_add", out_result, 16'h000E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
